// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for a multicycle MIPS-style datapath
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       regdst,
    output logic       memtoreg,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       branch,
    output logic       pcen,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q, state_d;
    logic   op_known;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    assign op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYP) ||
                      (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:    if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // op is consulted only to flag an unsupported instruction finishing in DECODE
    always_comb begin
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        branch     = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                instr_done = ~op_known;
            end
            S_MEMADR, S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // reset kills every strobe immediately, whatever state is registered
        if (rst) begin
            irwrite    = 1'b0;
            pcwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            branch     = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed and random checks of multicycle_controller against an instruction-level model
module tb_multicycle_controller;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [5:0] op;
    logic       iord, alusrca, regdst, memtoreg, irwrite, pcwrite, memwrite, regwrite, branch, pcen, instr_done;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    // model: remaining state list of the current instruction, plus cycle/wait counts
    int         q[$];
    int         cyc   = 1;
    int         waits = 0;
    logic [5:0] dec_op = 6'd0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
        .regdst(regdst), .memtoreg(memtoreg), .irwrite(irwrite), .pcwrite(pcwrite),
        .memwrite(memwrite), .regwrite(regwrite), .branch(branch), .pcen(pcen),
        .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic bit known(input logic [5:0] o);
        return o == LW || o == SW || o == RT || o == BEQ || o == ADDI || o == J;
    endfunction

    function automatic int base_lat(input logic [5:0] o);
        case (o)
            LW:           return 5;
            SW, RT, ADDI: return 4;
            BEQ, J:       return 3;
            default:      return 2;
        endcase
    endfunction

    // {iord, alusrca, alusrcb, aluop, pcsrc, regdst, memtoreg, irwrite, pcwrite, memwrite, regwrite, branch}
    function automatic logic [14:0] exp_ctrl(input int s, input logic mr, input logic r);
        logic io, asa, rd, m2r, ir, pw, mw, rw, br;
        logic [1:0] asb, aop, ps;
        {io, asa, rd, m2r, ir, pw, mw, rw, br} = '0;
        {asb, aop, ps} = '0;
        case (s)
            0:    begin asb = 2'b01; ir = mr; pw = mr; end
            1:    asb = 2'b11;
            2, 9: begin asa = 1'b1; asb = 2'b10; end
            3:    io = 1'b1;
            4:    begin m2r = 1'b1; rw = 1'b1; end
            5:    begin io = 1'b1; mw = 1'b1; end
            6:    begin asa = 1'b1; aop = 2'b10; end
            7:    begin rd = 1'b1; rw = 1'b1; end
            8:    begin asa = 1'b1; aop = 2'b01; ps = 2'b01; br = 1'b1; end
            10:   rw = 1'b1;
            11:   begin ps = 2'b10; pw = 1'b1; end
            default: ;
        endcase
        if (r) {ir, pw, mw, rw, br} = '0;
        return {io, asa, asb, aop, ps, rd, m2r, ir, pw, mw, rw, br};
    endfunction

    task automatic step(input logic r, input logic [5:0] o, input logic mr, input logic z);
        int         cur;
        logic [14:0] ec;
        logic       ed;
        rst = r; op = o; mem_ready = mr; zero = z;
        cur = q[0];
        ec  = exp_ctrl(cur, mr, r);
        ed  = !r && (cur == 4 || cur == 7 || cur == 8 || cur == 10 || cur == 11 ||
                     (cur == 5 && mr) || (cur == 1 && !known(o)));
        @(negedge clk);
        chk("state", state, cur);
        chk("ctrl", {iord, alusrca, alusrcb, aluop, pcsrc, regdst, memtoreg,
                     irwrite, pcwrite, memwrite, regwrite, branch}, ec);
        chk("pcen", pcen, ec[3] | (ec[0] & z));
        chk("instr_done", instr_done, ed);
        if (ed && instr_done === 1'b1)
            chk("latency", cyc, base_lat(cur == 1 ? o : dec_op) + waits);
        @(posedge clk);
        if (r) begin
            q.delete(); q.push_back(0);
        end else begin
            case (cur)
                0: if (mr) begin q.delete(); q.push_back(1); end else waits++;
                1: begin
                    dec_op = o;
                    q.delete();
                    case (o)
                        LW:      begin q.push_back(2); q.push_back(3); q.push_back(4); end
                        SW:      begin q.push_back(2); q.push_back(5); end
                        RT:      begin q.push_back(6); q.push_back(7); end
                        BEQ:     q.push_back(8);
                        ADDI:    begin q.push_back(9); q.push_back(10); end
                        J:       q.push_back(11);
                        default: q.push_back(0);
                    endcase
                end
                3, 5: if (mr) void'(q.pop_front()); else waits++;
                default: void'(q.pop_front());
            endcase
            if (q.size() == 0) q.push_back(0);
        end
        if (r || ed) begin cyc = 1; waits = 0; end
        else cyc++;
        #1;
    endtask

    task automatic run(input logic [5:0] o, input int n, input logic z);
        for (int i = 0; i < n; i++) step(1'b0, o, 1'b1, z);
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] o;
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ; ops[4] = ADDI; ops[5] = J; ops[6] = BAD;
        q.push_back(0);
        rst = 1'b1; op = 6'd0; mem_ready = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        step(1'b1, LW, 1'b1, 1'b1);
        step(1'b1, SW, 1'b0, 1'b0);

        run(LW, 5, 1'b0);
        run(RT, 4, 1'b1);
        run(BEQ, 3, 1'b1);
        run(RT, 4, 1'b0);
        run(BEQ, 3, 1'b0);

        run(SW, 3, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, SW, 1'b0, 1'b0);
        step(1'b0, SW, 1'b1, 1'b0);

        step(1'b0, ADDI, 1'b0, 1'b0);
        step(1'b0, ADDI, 1'b0, 1'b0);
        run(ADDI, 4, 1'b0);

        run(BAD, 2, 1'b0);

        run(LW, 3, 1'b0);
        step(1'b1, LW, 1'b0, 1'b1);
        step(1'b1, LW, 1'b1, 1'b1);
        run(J, 3, 1'b0);
        chk("after_j_state", state, 0);

        for (int i = 0; i < 3000; i++) begin
            o = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) o = 6'($urandom);
            if (q[0] == 2) o = dec_op;
            step(($urandom_range(0, 49) == 0), o, ($urandom_range(0, 9) < 7), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
